// File: rtl/stall_pipe.sv
// Buffered 4-phase handshake stage: accepts up to DEPTH tokens, holds each at
// least DELAY cycles, and re-issues them in FIFO order downstream.
module stall_pipe #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4,
    parameter int DELAY = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_in,
    input  logic [WIDTH-1:0]         data_in,
    output logic                     ack_out,
    output logic                     req_out,
    output logic [WIDTH-1:0]         data_out,
    input  logic                     ack_in,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    // DELAY=0 still needs a 1-bit counter so the storage is never zero-width
    localparam int AW = (DELAY > 0) ? $clog2(DELAY + 1) : 1;

    typedef enum logic {IN_IDLE, IN_ACK} in_state_e;
    typedef enum logic [1:0] {OUT_IDLE, OUT_REQ, OUT_WAIT} out_state_e;

    in_state_e        in_q, in_d;
    out_state_e       out_q, out_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    age_q [DEPTH];
    logic [PW-1:0]    wr_q, rd_q;
    logic [LW-1:0]    level_q, level_d;
    logic             push, pop;

    // Full test uses the pre-edge level, so a same-edge pop never admits a push
    assign push = (in_q == IN_IDLE) && req_in && (level_q != LW'(DEPTH));
    assign pop  = (out_q == OUT_REQ) && ack_in;

    always_comb begin
        in_d = in_q;
        case (in_q)
            IN_IDLE: if (push)    in_d = IN_ACK;
            IN_ACK:  if (!req_in) in_d = IN_IDLE;
            default:              in_d = IN_IDLE;
        endcase
    end

    always_comb begin
        out_d  = out_q;
        data_d = data_q;
        case (out_q)
            OUT_IDLE: begin
                if (level_q != '0 && age_q[rd_q] == '0) begin
                    out_d  = OUT_REQ;
                    data_d = mem_q[rd_q];
                end
            end
            OUT_REQ:  if (ack_in)  out_d = OUT_WAIT;
            OUT_WAIT: if (!ack_in) out_d = OUT_IDLE;
            default:               out_d = OUT_IDLE;
        endcase
    end

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_q   <= IN_IDLE;
            out_q  <= OUT_IDLE;
            data_q <= '0;
        end else begin
            in_q   <= in_d;
            out_q  <= out_d;
            data_q <= data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
                age_q[i] <= '0;
            end
        end else begin
            level_q <= level_d;
            if (push) wr_q <= wr_q + PW'(1);
            if (pop)  rd_q <= rd_q + PW'(1);
            for (int i = 0; i < DEPTH; i++) begin
                if (push && wr_q == PW'(i)) begin
                    mem_q[i] <= data_in;
                    age_q[i] <= AW'(DELAY);
                end else if (age_q[i] != '0) begin
                    age_q[i] <= age_q[i] - AW'(1);
                end
            end
        end
    end

    assign ack_out  = (in_q == IN_ACK);
    assign req_out  = (out_q == OUT_REQ);
    assign data_out = data_q;
    assign level    = level_q;
endmodule
